// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake,
// and selects the next PC from the controller's pcsrc/jump decision.
//
// state  | meaning
// BOOT   | first cycle after reset, no request
// FETCH  | imem_req high at pc, waiting for imem_ack
// EXEC   | instr valid, waiting for ex_done
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        ex_done,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] signimm,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [31:0] PC_RST = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;

  logic [31:0] pc_inc;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  assign pc_inc = pc_q + 32'd4;
  assign br_off = signimm << 2;

  // Jump outranks branch when the controller asserts both.
  always_comb begin
    next_pc = pc_inc;
    if (jump) begin
      next_pc = {pc_inc[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      next_pc = pc_inc + br_off;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    retired_d     = retired_q;
    imem_req_d    = imem_req_q;
    instr_valid_d = instr_valid_q;
    case (state_q)
      ST_BOOT: begin
        state_d       = ST_FETCH;
        imem_req_d    = 1'b1;
        instr_valid_d = 1'b0;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_rdata;
          state_d       = ST_EXEC;
          imem_req_d    = 1'b0;
          instr_valid_d = 1'b1;
        end
      end
      ST_EXEC: begin
        if (ex_done) begin
          pc_d          = next_pc;
          retired_d     = retired_q + 32'd1;
          state_d       = ST_FETCH;
          imem_req_d    = 1'b1;
          instr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d       = ST_BOOT;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= PC_RST;
      instr_q       <= 32'h0;
      retired_q     <= 32'h0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      retired_q     <= retired_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign pcplus4     = pc_inc;
  assign retired     = retired_q;

endmodule
